// File: rtl/vm_balance_ledger.sv
// vm_balance_ledger: running balance for the vending machine return/timeout path.
// Accepts coin and item-select pulses, debits return_total, and reports the
// balance plus one-cycle input/output activity totals.
// Optional build macro: BALANCE_CAP_EN (refuse coin sets that would exceed BALANCE_CAP).
module vm_balance_ledger #(
    parameter int unsigned                 NUM_COINS   = 3,
    parameter int unsigned                 NUM_ITEMS   = 4,
    parameter int unsigned                 TOTAL_BITS  = 31,
    parameter logic [NUM_COINS*32-1:0]     COIN_VALUES = {32'd1000, 32'd500, 32'd100},
    parameter logic [NUM_ITEMS*32-1:0]     ITEM_PRICES = {32'd2000, 32'd1000, 32'd500, 32'd400},
    parameter logic [TOTAL_BITS-1:0]       BALANCE_CAP = 31'd5000
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [NUM_COINS-1:0]  i_input_coin,
    input  logic [NUM_ITEMS-1:0]  i_select_item,
    input  logic [TOTAL_BITS-1:0] return_total,
    output logic [TOTAL_BITS-1:0] current_total,
    output logic [TOTAL_BITS-1:0] input_total,
    output logic [TOTAL_BITS-1:0] output_total,
    output logic [NUM_ITEMS-1:0]  o_output_item,
    output logic [NUM_ITEMS-1:0]  o_available_item,
    output logic [NUM_COINS-1:0]  o_reject_coin,
    output logic                  o_error
);

    localparam int unsigned CALC_BITS = TOTAL_BITS + 2;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_CREDIT    = 2'd1,
        ST_RETURNING = 2'd2
    } state_e;

    state_e                 state_q, state_d;
    logic [TOTAL_BITS-1:0]  current_total_q, current_total_d;
    logic [TOTAL_BITS-1:0]  input_total_q, input_total_d;
    logic [TOTAL_BITS-1:0]  output_total_q, output_total_d;
    logic [NUM_ITEMS-1:0]   output_item_q, output_item_d;
    logic [NUM_COINS-1:0]   reject_coin_q, reject_coin_d;
    logic                   error_q, error_d;

    logic [TOTAL_BITS-1:0]  coin_raw;
    logic [TOTAL_BITS-1:0]  coin_sum;
    logic [TOTAL_BITS-1:0]  item_price;
    logic                   item_hit;
    logic signed [CALC_BITS-1:0] next_sum;
    logic                   negative;
    logic                   unused_carry;
`ifdef BALANCE_CAP_EN
    logic signed [CALC_BITS-1:0] pre_cap;
`else
    logic                   unused_cap;
    assign unused_cap = ^BALANCE_CAP;
`endif

    assign unused_carry = next_sum[TOTAL_BITS];

    // Affordability flags from the registered balance; nothing is offered while returning.
    always_comb begin
        o_available_item = '0;
        for (int i = 0; i < NUM_ITEMS; i++) begin
            o_available_item[i] = (state_q != ST_RETURNING) &&
                                  (ITEM_PRICES[i*32 +: TOTAL_BITS] <= current_total_q);
        end
    end

    // Ledger update: coin acceptance, item arbitration, balance arithmetic and next state.
    always_comb begin
        coin_raw        = '0;
        coin_sum        = '0;
        item_price      = '0;
        item_hit        = 1'b0;
        output_item_d   = '0;
        reject_coin_d   = '0;
        state_d         = state_q;
`ifdef BALANCE_CAP_EN
        pre_cap         = '0;
`endif

        for (int i = 0; i < NUM_COINS; i++) begin
            if (i_input_coin[i]) begin
                coin_raw = coin_raw + COIN_VALUES[i*32 +: TOTAL_BITS];
            end
        end

        // Lowest affordable selected slot wins; priced against the pre-update balance.
        if (state_q == ST_CREDIT) begin
            for (int i = 0; i < NUM_ITEMS; i++) begin
                if (!item_hit && i_select_item[i] &&
                    (ITEM_PRICES[i*32 +: TOTAL_BITS] <= current_total_q)) begin
                    item_hit         = 1'b1;
                    item_price       = ITEM_PRICES[i*32 +: TOTAL_BITS];
                    output_item_d[i] = 1'b1;
                end
            end
        end

        if (state_q == ST_RETURNING) begin
            reject_coin_d = i_input_coin;
        end else begin
`ifdef BALANCE_CAP_EN
            pre_cap = $signed({2'b00, current_total_q}) + $signed({2'b00, coin_raw})
                    - $signed({2'b00, item_price});
            if (pre_cap > $signed({2'b00, BALANCE_CAP})) begin
                reject_coin_d = i_input_coin;
            end else begin
                coin_sum = coin_raw;
            end
`else
            coin_sum = coin_raw;
`endif
        end

        next_sum = $signed({2'b00, current_total_q}) + $signed({2'b00, coin_sum})
                 - $signed({2'b00, item_price}) - $signed({2'b00, return_total});
        negative = next_sum[CALC_BITS-1];

        current_total_d = negative ? '0 : next_sum[TOTAL_BITS-1:0];
        input_total_d   = coin_sum;
        output_total_d  = item_price;
        error_d         = error_q | negative;

        case (state_q)
            ST_IDLE: begin
                if (coin_sum != '0) state_d = ST_CREDIT;
            end
            ST_CREDIT: begin
                if (return_total != '0)          state_d = ST_RETURNING;
                else if (current_total_d == '0)  state_d = ST_IDLE;
            end
            ST_RETURNING: begin
                state_d = (current_total_q == '0) ? ST_IDLE : ST_CREDIT;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and output registers; reset discards the balance without a return.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q         <= ST_IDLE;
            current_total_q <= '0;
            input_total_q   <= '0;
            output_total_q  <= '0;
            output_item_q   <= '0;
            reject_coin_q   <= '0;
            error_q         <= 1'b0;
        end else begin
            state_q         <= state_d;
            current_total_q <= current_total_d;
            input_total_q   <= input_total_d;
            output_total_q  <= output_total_d;
            output_item_q   <= output_item_d;
            reject_coin_q   <= reject_coin_d;
            error_q         <= error_d;
        end
    end

    assign current_total = current_total_q;
    assign input_total   = input_total_q;
    assign output_total  = output_total_q;
    assign o_output_item = output_item_q;
    assign o_reject_coin = reject_coin_q;
    assign o_error       = error_q;

endmodule

// File: tb/tb_vm_balance_ledger.sv
// Directed vector bench for vm_balance_ledger.
// Coin bits: [0]=100 [1]=500 [2]=1000. Item bits: [0]=400 [1]=500 [2]=1000 [3]=2000.
module tb_vm_balance_ledger;

    logic        clk;
    logic        reset_n;
    logic [2:0]  i_input_coin;
    logic [3:0]  i_select_item;
    logic [30:0] return_total;
    logic [30:0] current_total;
    logic [30:0] input_total;
    logic [30:0] output_total;
    logic [3:0]  o_output_item;
    logic [3:0]  o_available_item;
    logic [2:0]  o_reject_coin;
    logic        o_error;

    int n_checks = 0;
    int n_fail   = 0;

    vm_balance_ledger dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .i_input_coin     (i_input_coin),
        .i_select_item    (i_select_item),
        .return_total     (return_total),
        .current_total    (current_total),
        .input_total      (input_total),
        .output_total     (output_total),
        .o_output_item    (o_output_item),
        .o_available_item (o_available_item),
        .o_reject_coin    (o_reject_coin),
        .o_error          (o_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  coin;
        logic [3:0]  sel;
        logic [30:0] ret;
        logic [30:0] cur;
        logic [30:0] in_t;
        logic [30:0] out_t;
        logic [3:0]  item;
        logic [3:0]  avail;
        logic [2:0]  rej;
        logic        err;
    } vec_t;

    localparam int NV = 20;
    vec_t vecs [NV];

    function automatic vec_t mk(input logic [2:0] coin, input logic [3:0] sel,
                                input int ret, input int cur, input int in_t,
                                input int out_t, input logic [3:0] item,
                                input logic [3:0] avail, input logic [2:0] rej,
                                input logic err);
        vec_t v;
        v.coin = coin; v.sel = sel; v.ret = 31'(ret);
        v.cur = 31'(cur); v.in_t = 31'(in_t); v.out_t = 31'(out_t);
        v.item = item; v.avail = avail; v.rej = rej; v.err = err;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input int cur, input int in_t, input int out_t,
                             input logic [3:0] item, input logic [3:0] avail,
                             input logic [2:0] rej, input logic err);
        check({tag, " current_total"},    32'(current_total),    32'(cur));
        check({tag, " input_total"},      32'(input_total),      32'(in_t));
        check({tag, " output_total"},     32'(output_total),     32'(out_t));
        check({tag, " o_output_item"},    32'(o_output_item),    32'(item));
        check({tag, " o_available_item"}, 32'(o_available_item), 32'(avail));
        check({tag, " o_reject_coin"},    32'(o_reject_coin),    32'(rej));
        check({tag, " o_error"},          32'(o_error),          32'(err));
    endtask

    // One clock with the given inputs; leaves inputs idle and samples 1 time unit after the edge.
    task automatic cyc(input logic [2:0] coin, input logic [3:0] sel, input int ret);
        i_input_coin  = coin;
        i_select_item = sel;
        return_total  = 31'(ret);
        @(posedge clk);
        #1;
        i_input_coin  = '0;
        i_select_item = '0;
        return_total  = '0;
    endtask

    initial begin
        //               coin    sel      ret   cur   in    out   item     avail    rej     err
        vecs[0]  = mk(3'b100, 4'b0000,   0, 1000, 1000,    0, 4'b0000, 4'b0111, 3'b000, 1'b0);
        vecs[1]  = mk(3'b010, 4'b0000,   0, 1500,  500,    0, 4'b0000, 4'b0111, 3'b000, 1'b0);
        vecs[2]  = mk(3'b000, 4'b1010,   0, 1000,    0,  500, 4'b0010, 4'b0111, 3'b000, 1'b0);
        vecs[3]  = mk(3'b000, 4'b0000,   0, 1000,    0,    0, 4'b0000, 4'b0111, 3'b000, 1'b0);
        vecs[4]  = mk(3'b000, 4'b0000, 1000,   0,    0,    0, 4'b0000, 4'b0000, 3'b000, 1'b0);
        vecs[5]  = mk(3'b001, 4'b0000,   0,    0,    0,    0, 4'b0000, 4'b0000, 3'b001, 1'b0);
        vecs[6]  = mk(3'b001, 4'b0000,   0,  100,  100,    0, 4'b0000, 4'b0000, 3'b000, 1'b0);
        vecs[7]  = mk(3'b000, 4'b0001,   0,  100,    0,    0, 4'b0000, 4'b0000, 3'b000, 1'b0);
        vecs[8]  = mk(3'b110, 4'b0001,   0, 1600, 1500,    0, 4'b0000, 4'b0111, 3'b000, 1'b0);
        vecs[9]  = mk(3'b000, 4'b1111,   0, 1200,    0,  400, 4'b0001, 4'b0111, 3'b000, 1'b0);
        vecs[10] = mk(3'b000, 4'b0100,   0,  200,    0, 1000, 4'b0100, 4'b0000, 3'b000, 1'b0);
        vecs[11] = mk(3'b011, 4'b0000,   0,  800,  600,    0, 4'b0000, 4'b0011, 3'b000, 1'b0);
        vecs[12] = mk(3'b000, 4'b0001,   0,  400,    0,  400, 4'b0001, 4'b0001, 3'b000, 1'b0);
        vecs[13] = mk(3'b000, 4'b0001,   0,    0,    0,  400, 4'b0001, 4'b0000, 3'b000, 1'b0);
        vecs[14] = mk(3'b000, 4'b0000,   0,    0,    0,    0, 4'b0000, 4'b0000, 3'b000, 1'b0);
        vecs[15] = mk(3'b000, 4'b0001,   0,    0,    0,    0, 4'b0000, 4'b0000, 3'b000, 1'b0);
        vecs[16] = mk(3'b001, 4'b0000,   0,  100,  100,    0, 4'b0000, 4'b0000, 3'b000, 1'b0);
        vecs[17] = mk(3'b000, 4'b0000, 500,    0,    0,    0, 4'b0000, 4'b0000, 3'b000, 1'b1);
        vecs[18] = mk(3'b100, 4'b0000,   0,    0,    0,    0, 4'b0000, 4'b0000, 3'b100, 1'b1);
        vecs[19] = mk(3'b100, 4'b0000,   0, 1000, 1000,    0, 4'b0000, 4'b0111, 3'b000, 1'b1);

        reset_n       = 1'b0;
        i_input_coin  = '0;
        i_select_item = '0;
        return_total  = '0;
        repeat (2) @(posedge clk);
        #1;
        check_all("reset", 0, 0, 0, 4'b0000, 4'b0000, 3'b000, 1'b0);
        reset_n = 1'b1;

        for (int r = 0; r < NV; r++) begin
            cyc(vecs[r].coin, vecs[r].sel, int'(vecs[r].ret));
            check_all($sformatf("row%0d", r), int'(vecs[r].cur), int'(vecs[r].in_t),
                      int'(vecs[r].out_t), vecs[r].item, vecs[r].avail, vecs[r].rej,
                      vecs[r].err);
        end

        // Asynchronous reset in the middle of a cycle clears the sticky error and balance.
        #3;
        reset_n = 1'b0;
        #1;
        check_all("async_reset", 0, 0, 0, 4'b0000, 4'b0000, 3'b000, 1'b0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        cyc(3'b000, 4'b0000, 0);
        check_all("post_reset", 0, 0, 0, 4'b0000, 4'b0000, 3'b000, 1'b0);

        // Build to 4500, then a 1000 coin: capped build refuses it, default build wraps nothing yet.
        for (int k = 0; k < 4; k++) cyc(3'b100, 4'b0000, 0);
        cyc(3'b010, 4'b0000, 0);
        check_all("cap_pre", 4500, 500, 0, 4'b0000, 4'b1111, 3'b000, 1'b0);
        cyc(3'b100, 4'b0000, 0);
`ifdef BALANCE_CAP_EN
        check_all("cap_coin", 4500, 0, 0, 4'b0000, 4'b1111, 3'b100, 1'b0);
`else
        check_all("cap_coin", 5500, 1000, 0, 4'b0000, 4'b1111, 3'b000, 1'b0);
`endif
        cyc(3'b000, 4'b0000, 0);
        check("cap_idle input_total", 32'(input_total), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
